// File: rtl/vldst_pkg.sv
// Shared types and geometry helpers for the vector load/store sequencer.
package vldst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int line_bytes(input int block_w);
        return block_w / 8;
    endfunction

endpackage

// File: rtl/vldst_chunk_calc.sv
// Size of the next cache chunk: the remaining bytes, clipped at the end of the current line.
module vldst_chunk_calc
    import vldst_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int BLOCK_W = 256,
    parameter int SIZE_W  = 6
) (
    input  logic [ADDR_W-1:0] cur_addr_i,
    input  logic [SIZE_W:0]   remaining_i,
    output logic [SIZE_W:0]   chunk_o
);

    localparam int LINE_BYTES = line_bytes(BLOCK_W);
    localparam int CW         = (ADDR_W > SIZE_W + 1) ? ADDR_W : SIZE_W + 1;

    logic [CW-1:0] addr_ext;
    logic [CW-1:0] line_ext;
    logic [CW-1:0] rem_ext;
    logic [CW-1:0] room;

    // LINE_BYTES is a power of two, so the in-line offset is a simple mask.
    always_comb begin
        addr_ext = CW'(cur_addr_i);
        line_ext = CW'(LINE_BYTES);
        rem_ext  = CW'(remaining_i);
        room     = line_ext - (addr_ext & (line_ext - 1'b1));
        chunk_o  = (rem_ext < room) ? remaining_i : room[SIZE_W:0];
    end

endmodule

// File: rtl/vldst_sequencer.sv
// Splits a vector load/store into line-bounded cache requests, one at a time, and assembles load data.
module vldst_sequencer
    import vldst_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int BLOCK_W = 256,
    parameter int SIZE_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_store,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [SIZE_W-1:0] in_size,
    input  logic [DATA_W-1:0] in_data,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_store,
    output logic [ADDR_W-1:0] req_addr,
    output logic [SIZE_W-1:0] req_size,
    output logic [DATA_W-1:0] req_data,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [DATA_W-1:0] done_data,
    output logic              done_exc
);

    localparam int              DATA_BYTES = DATA_W / 8;
    localparam logic [SIZE_W:0] MAX_BYTES  = (SIZE_W + 1)'(DATA_BYTES);

    state_e              state_q, state_d;
    logic                store_q, store_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SIZE_W:0]     size_q, size_d;
    logic [SIZE_W:0]     done_q, done_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic                exc_q, exc_d;

    logic [SIZE_W:0]     in_size_ext;
    logic [SIZE_W:0]     remaining;
    logic [SIZE_W:0]     chunk;
    logic [SIZE_W+1:0]   chunk_end;
    logic [DATA_W-1:0]   resp_shift;

    assign in_size_ext = {1'b0, in_size};
    assign remaining   = size_q - done_q;

    vldst_chunk_calc #(
        .ADDR_W  (ADDR_W),
        .BLOCK_W (BLOCK_W),
        .SIZE_W  (SIZE_W)
    ) u_chunk_calc (
        .cur_addr_i  (addr_q),
        .remaining_i (remaining),
        .chunk_o     (chunk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) begin
                if (in_size_ext == '0 || in_size_ext > MAX_BYTES) state_d = DONE;
                else                                              state_d = ISSUE;
            end
            ISSUE: if (req_ready)  state_d = WAIT;
            WAIT:  if (resp_valid) state_d = (chunk == remaining) ? DONE : ISSUE;
            DONE:  if (done_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        req_valid  = (state_q == ISSUE);
        done_valid = (state_q == DONE);
    end

    // Response bytes land at offset done_q; only the chunk's own byte lanes are updated.
    always_comb begin
        store_d    = store_q;
        addr_d     = addr_q;
        size_d     = size_q;
        done_d     = done_q;
        data_d     = data_q;
        asm_d      = asm_q;
        exc_d      = exc_q;
        resp_shift = resp_data << (8 * done_q);
        chunk_end  = {1'b0, done_q} + {1'b0, chunk};
        if (state_q == IDLE && in_valid) begin
            store_d = in_store;
            addr_d  = in_addr;
            size_d  = in_size_ext;
            done_d  = '0;
            data_d  = in_data;
            asm_d   = '0;
            exc_d   = (in_size_ext > MAX_BYTES);
        end else if (state_q == WAIT && resp_valid) begin
            addr_d = addr_q + ADDR_W'(chunk);
            done_d = done_q + chunk;
            if (!store_q) begin
                for (int j = 0; j < DATA_BYTES; j++) begin
                    if ((SIZE_W + 2)'(j) >= {1'b0, done_q} && (SIZE_W + 2)'(j) < chunk_end)
                        asm_d[8*j +: 8] = resp_shift[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            done_q  <= '0;
            data_q  <= '0;
            asm_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            store_q <= store_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            done_q  <= done_d;
            data_q  <= data_d;
            asm_q   <= asm_d;
            exc_q   <= exc_d;
        end
    end

    assign req_store = store_q;
    assign req_addr  = addr_q;
    assign req_size  = chunk[SIZE_W-1:0];
    assign req_data  = data_q >> (8 * done_q);
    assign done_data = asm_q;
    assign done_exc  = exc_q;

endmodule

// File: tb/tb_vldst_sequencer.sv
// Directed bench for vldst_sequencer with BLOCK_W = DATA_W = 256.
module tb_vldst_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_store;
    logic [31:0]  in_addr;
    logic [5:0]   in_size;
    logic [255:0] in_data;
    logic         req_valid, req_ready, req_store;
    logic [31:0]  req_addr;
    logic [5:0]   req_size;
    logic [255:0] req_data;
    logic         resp_valid;
    logic [255:0] resp_data;
    logic         done_valid, done_ready;
    logic [255:0] done_data;
    logic         done_exc;

    int errors = 0;
    int checks = 0;

    vldst_sequencer #(
        .ADDR_W  (32),
        .DATA_W  (256),
        .BLOCK_W (256),
        .SIZE_W  (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_store   (in_store),
        .in_addr    (in_addr),
        .in_size    (in_size),
        .in_data    (in_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_data  (done_data),
        .done_exc   (done_exc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic st, input logic [31:0] a, input logic [5:0] sz,
                            input logic [255:0] d);
        chk("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in_store = st;
        in_addr  = a;
        in_size  = sz;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_store = ~st;
        in_addr  = $urandom;
        in_size  = 6'($urandom);
        in_data  = rnd256();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_valid"}, req_valid, 1'b1);
    endtask

    task automatic serve(input string tag, input logic [31:0] ea, input logic [5:0] es,
                         input logic est, input logic chk_data, input logic [255:0] ed,
                         input logic [255:0] r);
        wait_req(tag);
        chk({tag, "_addr"}, req_addr, ea);
        chk({tag, "_size"}, req_size, es);
        chk({tag, "_store"}, req_store, est);
        if (chk_data) chk({tag, "_data"}, req_data, ed);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk({tag, "_wait_noreq"}, req_valid, 1'b0);
        resp_valid = 1'b1;
        resp_data  = r;
        tick();
        resp_valid = 1'b0;
        resp_data  = rnd256();
    endtask

    task automatic finish_op(input string tag, input logic [255:0] ed, input logic ee);
        int n = 0;
        while (!done_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done_valid"}, done_valid, 1'b1);
        chk({tag, "_done_data"}, done_data, ed);
        chk({tag, "_done_exc"}, done_exc, ee);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk({tag, "_back_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [255:0] p, a, b, d;
        logic         saw_req, saw_done;
        int           n;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_store   = 1'b0;
        in_addr    = '0;
        in_size    = '0;
        in_data    = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        done_ready = 1'b0;

        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_done_exc", done_exc, 1'b0);
        chk("rst_done_data", done_data, '0);
        chk("rst_req_addr", req_addr, '0);
        chk("rst_req_size", req_size, '0);
        #10 rst = 1'b0;
        tick();

        // Aligned full-line load.
        p = rnd256();
        start_op(1'b0, 32'h100, 6'd32, '0);
        chk("al_req_latency", req_valid, 1'b1);
        serve("al", 32'h100, 6'd32, 1'b0, 1'b0, '0, p);
        finish_op("al", p, 1'b0);

        // Line-crossing load.
        a = rnd256();
        b = rnd256();
        start_op(1'b0, 32'h110, 6'd32, '0);
        serve("lx1", 32'h110, 6'd16, 1'b0, 1'b0, '0, a);
        serve("lx2", 32'h120, 6'd16, 1'b0, 1'b0, '0, b);
        finish_op("lx", {b[127:0], a[127:0]}, 1'b0);

        // Line-crossing store.
        d = 256'h1122334455667788;
        start_op(1'b1, 32'h11C, 6'd8, d);
        serve("sx1", 32'h11C, 6'd4, 1'b1, 1'b1, d, rnd256());
        serve("sx2", 32'h120, 6'd4, 1'b1, 1'b1, 256'h11223344, rnd256());
        finish_op("sx", '0, 1'b0);

        // Short load: bytes above in_size must be zero despite earlier contents.
        a = rnd256();
        start_op(1'b0, 32'h104, 6'd3, '0);
        serve("sh", 32'h104, 6'd3, 1'b0, 1'b0, '0, a);
        finish_op("sh", {232'd0, a[23:0]}, 1'b0);

        // Backpressure on request and completion; stray responses in ISSUE are ignored.
        p = rnd256();
        start_op(1'b0, 32'h200, 6'd32, '0);
        wait_req("bp");
        for (int i = 0; i < 5; i++) begin
            resp_valid = 1'b1;
            resp_data  = rnd256();
            chk("bp_req_valid", req_valid, 1'b1);
            chk("bp_req_addr", req_addr, 32'h200);
            chk("bp_req_size", req_size, 6'd32);
            tick();
        end
        resp_valid = 1'b0;
        serve("bp", 32'h200, 6'd32, 1'b0, 1'b0, '0, p);
        for (int i = 0; i < 3; i++) begin
            chk("bp_done_valid", done_valid, 1'b1);
            chk("bp_done_data", done_data, p);
            tick();
        end
        finish_op("bp", p, 1'b0);

        // Zero-size operation.
        saw_req = 1'b0;
        start_op(1'b0, 32'h40, 6'd0, rnd256());
        saw_req = req_valid;
        n = 0;
        while (!done_valid && n < 2) begin
            tick();
            n++;
            saw_req |= req_valid;
        end
        chk("sz0_done", done_valid, 1'b1);
        chk("sz0_noreq", saw_req, 1'b0);
        finish_op("sz0", '0, 1'b0);

        // Oversize operation.
        saw_req = 1'b0;
        start_op(1'b0, 32'h80, 6'd33, rnd256());
        saw_req = req_valid;
        n = 0;
        while (!done_valid && n < 2) begin
            tick();
            n++;
            saw_req |= req_valid;
        end
        chk("sz33_noreq", saw_req, 1'b0);
        finish_op("sz33", '0, 1'b1);

        // Address wrap across the top of the address space.
        a = rnd256();
        b = rnd256();
        start_op(1'b0, 32'hFFFF_FFF0, 6'd32, '0);
        serve("wr1", 32'hFFFF_FFF0, 6'd16, 1'b0, 1'b0, '0, a);
        serve("wr2", 32'h0000_0000, 6'd16, 1'b0, 1'b0, '0, b);
        finish_op("wr", {b[127:0], a[127:0]}, 1'b0);

        // Reset while waiting for a response.
        start_op(1'b0, 32'h100, 6'd32, '0);
        wait_req("rw");
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rw_in_ready", in_ready, 1'b1);
        chk("rw_req_valid", req_valid, 1'b0);
        chk("rw_done_valid", done_valid, 1'b0);
        chk("rw_done_data", done_data, '0);
        #2 rst = 1'b0;
        tick();
        resp_valid = 1'b1;
        resp_data  = rnd256();
        tick();
        resp_valid = 1'b0;
        saw_req  = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            saw_req  |= req_valid;
            saw_done |= done_valid;
            tick();
        end
        chk("rw_no_done", saw_done, 1'b0);
        chk("rw_no_req", saw_req, 1'b0);
        chk("rw_idle", in_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vldst_sequencer.md
VLDST_SEQUENCER -- requirements
Module: vldst_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter DATA_W, default 256: vector transfer width in bits, a multiple of 8.
REQ-003 SHALL have parameter BLOCK_W, default 256: cache line width in bits, a power of two, at most DATA_W.
REQ-004 SHALL have parameter SIZE_W, default 6: width of the byte-count fields.
REQ-005 SHALL have clk, input, 1: the single clock.
REQ-006 SHALL have rst, input, 1: the reset, asynchronous and active-high.
REQ-007 SHALL have in_valid/in_ready, input/output, 1/1: the operation handshake.
REQ-008 SHALL have in_store, in_addr, in_size, in_data, inputs, 1/ADDR_W/SIZE_W/DATA_W: store flag, byte address, byte count and store data.
REQ-009 SHALL have req_valid/req_ready, output/input, 1/1: the cache request handshake.
REQ-010 SHALL have req_store, req_addr, req_size, req_data, outputs, 1/ADDR_W/SIZE_W/DATA_W: the request for one chunk.
REQ-011 SHALL have resp_valid, resp_data, inputs, 1/DATA_W: the chunk completion; load data is aligned to bit 0.
REQ-012 SHALL have done_valid/done_ready, output/input, 1/1: the completion handshake.
REQ-013 SHALL have done_data, done_exc, outputs, DATA_W/1: the assembled load data and the size-error flag.

Function
REQ-014 SHALL use an FSM with states IDLE, ISSUE, WAIT, DONE.
REQ-015 SHALL assert in_ready only in IDLE.
REQ-016 SHALL move IDLE→ISSUE when in_valid&in_ready in cycle T; req_valid rises in cycle T+1.
REQ-017 SHALL latch in_store, in_addr, in_size and in_data on acceptance, so input changes afterwards have no effect.
REQ-018 SHALL give each chunk req_size = min(remaining, LINE_BYTES − (cur_addr mod LINE_BYTES)), where LINE_BYTES = BLOCK_W/8; no chunk crosses a line boundary.
REQ-019 SHALL drive req_addr = cur_addr and req_store = the latched in_store.
REQ-020 SHALL drive req_data = latched in_data >> (8·bytes_done); all request fields stay stable while req_valid&!req_ready.
REQ-021 SHALL move ISSUE→WAIT on req_valid&req_ready, deasserting req_valid the next cycle; at most one chunk is outstanding.
REQ-022 SHALL ignore resp_valid outside WAIT.
REQ-023 SHALL, on resp_valid in WAIT for a load, write bytes [0, req_size) of resp_data into assembly bytes [bytes_done, bytes_done+req_size); other assembly bytes keep their value.
REQ-024 SHALL, on resp_valid in WAIT, add req_size to cur_addr and bytes_done; the state goes to ISSUE if bytes remain, otherwise to DONE.
REQ-025 SHALL clear the assembly register on operation acceptance, so done_data bytes at or above in_size are zero.
REQ-026 SHALL make done_data zero for stores.
REQ-027 SHALL assert done_valid throughout DONE and return to IDLE on done_valid&done_ready; done_data stays stable while done_valid&!done_ready.
REQ-028 SHALL, for in_size = 0, go IDLE→DONE with no cache request and done_exc = 0.
REQ-029 SHALL, for in_size > DATA_W/8, go IDLE→DONE with no cache request, done_exc = 1 and done_data = 0.
REQ-030 SHALL let cur_addr wrap modulo 2^ADDR_W.
REQ-031 SHALL perform the chunk arithmetic in SIZE_W+1 bits, with no truncation at in_size = DATA_W/8.

Reset
REQ-032 SHALL, while rst is high (asynchronous), force state IDLE, in_ready = 1, and req_valid, done_valid, done_exc = 0.
REQ-033 SHALL also clear req_* fields, done_data, the assembly register and the counters to 0.
REQ-034 SHALL drop any operation in progress on reset mid-operation, with no further req_valid or done_valid; a response that arrives later is ignored.

Structure
REQ-035 SHALL place the FSM state enum (IDLE/ISSUE/WAIT/DONE) and the LINE_BYTES derivation in package vldst_pkg.
REQ-036 SHALL put the combinational chunk-size computation (REQ-018) in sub-module vldst_chunk_calc, instantiated once.

Verification (BLOCK_W = DATA_W = 256)
REQ-037 SHALL cover an aligned load: addr 0x100, size 32 → one request (0x100, 32); resp_data = pattern P → done_data = P.
REQ-038 SHALL cover a line-crossing load: addr 0x110, size 32 → requests (0x110, 16) then (0x120, 16); resp A then B → done_data = {B[127:0], A[127:0]}.
REQ-039 SHALL cover a line-crossing store: addr 0x11C, size 8, data 0x1122334455667788 → requests (0x11C, 4, data …55667788) and (0x120, 4, data 0x11223344); done_data = 0.
REQ-040 SHALL cover backpressure: req_ready held low for 5 cycles → req_* stable; done_ready low for 3 cycles → done_data stable.
REQ-041 SHALL cover size edge cases: size 0 → done_valid 2 cycles after acceptance with no req_valid; size 33 → done_exc = 1 with no req_valid.
REQ-042 SHALL cover reset during WAIT: rst pulsed → in_ready = 1 in the same cycle; a later resp_valid produces no done_valid.
